// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared rv32 decode types: opcodes, control enums, ctrl bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;

    // addi x0, x0, 0
    localparam logic [31:0] c_NOP = 32'h00000013;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    typedef struct packed {
        imm_src_t    imm_src;
        logic        reg_write;
        logic        mem_write;
        logic        alu_src;
        logic        branch;
        logic        jump;
        result_src_t result_src;
        alu_op_t     alu_op;
        logic        uses_rs2;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t c_CTRL_ZERO = '0;

    function automatic logic opcode_supported(input logic [6:0] opc);
        case (opc)
            c_OPC_LOAD, c_OPC_STORE, c_OPC_OP, c_OPC_OP_IMM,
            c_OPC_BRANCH, c_OPC_JAL, c_OPC_JALR: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_lut.sv
`default_nettype none
// ============================================================================
// Module      : decode_lut
// Description : Pure combinational opcode to control-bundle mapping.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_lut
    import core_pkg::*;
(
    input  logic [6:0]   opcode,
    output ctrl_bundle_t ctrl
);

    always_comb begin
        ctrl = c_CTRL_ZERO;
        case (opcode)
            c_OPC_LOAD: begin
                ctrl.imm_src    = IMM_I;
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_MEM;
            end
            c_OPC_STORE: begin
                ctrl.imm_src    = IMM_S;
                ctrl.mem_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.uses_rs2   = 1'b1;
            end
            c_OPC_OP: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_op     = ALU_FUNCT;
                ctrl.uses_rs2   = 1'b1;
            end
            c_OPC_OP_IMM: begin
                ctrl.imm_src    = IMM_I;
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.alu_op     = ALU_FUNCT;
            end
            c_OPC_BRANCH: begin
                ctrl.imm_src    = IMM_B;
                ctrl.branch     = 1'b1;
                ctrl.alu_op     = ALU_SUB;
                ctrl.uses_rs2   = 1'b1;
            end
            c_OPC_JAL: begin
                ctrl.imm_src    = IMM_J;
                ctrl.jump       = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_PC4;
            end
            c_OPC_JALR: begin
                ctrl.imm_src    = IMM_I;
                ctrl.jump       = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_PC4;
            end
            default: ctrl = c_CTRL_ZERO;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/decode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : decode_ctrl
// Description : rv32 ID stage: pipeline register, decode, handshake, load-use
//               bubble and flush. Optional illegal-opcode trap is enabled by
//               defining DECODE_ILLEGAL_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_ctrl
    import core_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [24:0]     base_imm,
    output logic [1:0]      imm_src,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic            reg_write,
    output logic            mem_write,
    output logic            alu_src,
    output logic            branch,
    output logic            jump,
    output logic [1:0]      result_src,
    output logic [1:0]      alu_op,
    output logic            illegal
);

    logic            r_id_valid;
    logic [XLEN-1:0] r_instr;
    logic [PC_W-1:0] r_pc;
    logic [4:0]      r_last_load_rd;

    logic [6:0]      w_opcode;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    ctrl_bundle_t    w_ctrl;
    ctrl_bundle_t    w_ctrl_out;
    logic            w_hazard;
    logic            w_out_valid;
    logic            w_out_fire;
    logic            w_in_ready;
    logic            w_in_fire;

    assign w_opcode = r_instr[6:0];
    assign w_rd     = r_instr[11:7];
    // JAL has no source registers; its rs fields are immediate bits
    assign w_rs1    = (w_opcode == c_OPC_JAL) ? 5'd0 : r_instr[19:15];
    assign w_rs2    = (w_opcode == c_OPC_JAL) ? 5'd0 : r_instr[24:20];

    decode_lut u_decode_lut (
        .opcode (w_opcode),
        .ctrl   (w_ctrl)
    );

    assign w_hazard = r_id_valid && (r_last_load_rd != 5'd0) &&
                      ((w_rs1 == r_last_load_rd) ||
                       (w_ctrl.uses_rs2 && (w_rs2 == r_last_load_rd)));

    assign w_out_valid = r_id_valid & ~w_hazard & ~flush;
    assign w_out_fire  = w_out_valid & out_ready;
    assign w_in_ready  = ~flush & (~r_id_valid | w_out_fire);
    assign w_in_fire   = in_valid & w_in_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_id_valid     <= 1'b0;
            r_instr        <= XLEN'(c_NOP);
            r_pc           <= '0;
            r_last_load_rd <= 5'd0;
        end else if (flush) begin
            r_id_valid     <= 1'b0;
            r_last_load_rd <= 5'd0;
        end else begin
            if (w_in_fire) begin
                r_id_valid <= 1'b1;
                r_instr    <= in_instr;
                r_pc       <= in_pc;
            end else if (w_out_fire) begin
                r_id_valid <= 1'b0;
            end

            // The bubble cycle consumes the pending load destination
            if (w_out_fire) begin
                r_last_load_rd <= ((w_opcode == c_OPC_LOAD) && (w_rd != 5'd0)) ? w_rd : 5'd0;
            end else if (w_hazard) begin
                r_last_load_rd <= 5'd0;
            end
        end
    end

    always_comb begin
        w_ctrl_out = c_CTRL_ZERO;
        if (r_id_valid) begin
            w_ctrl_out = w_ctrl;
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = w_out_valid;
    assign out_pc     = r_id_valid ? r_pc : '0;
    assign base_imm   = r_id_valid ? r_instr[31:7] : 25'd0;
    assign rs1        = r_id_valid ? w_rs1 : 5'd0;
    assign rs2        = r_id_valid ? w_rs2 : 5'd0;
    assign rd         = r_id_valid ? w_rd : 5'd0;
    assign imm_src    = w_ctrl_out.imm_src;
    assign reg_write  = w_ctrl_out.reg_write;
    assign mem_write  = w_ctrl_out.mem_write;
    assign alu_src    = w_ctrl_out.alu_src;
    assign branch     = w_ctrl_out.branch;
    assign jump       = w_ctrl_out.jump;
    assign result_src = w_ctrl_out.result_src;
    assign alu_op     = w_ctrl_out.alu_op;

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic        w_illegal;
    logic [15:0] r_illegal_count;

    // Unsupported opcodes already decode to an all-zero bundle, so no write enable leaks
    assign w_illegal = r_id_valid &
                       (~opcode_supported(w_opcode) | (r_instr[1:0] != 2'b11));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_illegal_count <= 16'd0;
        end else if (w_out_fire && w_illegal && (r_illegal_count != 16'hFFFF)) begin
            r_illegal_count <= r_illegal_count + 16'd1;
        end
    end

    assign illegal = w_illegal;
`else
    assign illegal = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_ctrl
// Description : Scoreboard bench for decode_ctrl with directed instruction vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_ctrl;

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam logic c_ILL_EN = 1'b1;
`else
    localparam logic c_ILL_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [24:0] base_imm;
        logic [1:0]  imm_src;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [4:0]  ctl;      // {reg_write, mem_write, alu_src, branch, jump}
        logic [1:0]  res;
        logic [1:0]  alu;
        logic        ill;
        int          gap;      // expected cycles since previous fire, 0 = don't care
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [24:0] base_imm;
    logic [1:0]  imm_src;
    logic [4:0]  rs1, rs2, rd;
    logic        reg_write, mem_write, alu_src, branch, jump;
    logic [1:0]  result_src;
    logic [1:0]  alu_op;
    logic        illegal;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_fire = 0;
    exp_t sb[$];
    exp_t m_e;

    decode_ctrl #(.XLEN(32), .PC_W(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .base_imm   (base_imm),
        .imm_src    (imm_src),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd),
        .reg_write  (reg_write),
        .mem_write  (mem_write),
        .alu_src    (alu_src),
        .branch     (branch),
        .jump       (jump),
        .result_src (result_src),
        .alu_op     (alu_op),
        .illegal    (illegal)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc, input logic [24:0] bi,
                                input logic [1:0] imm, input logic [4:0] r1,
                                input logic [4:0] r2, input logic [4:0] rdd,
                                input logic [4:0] ctl, input logic [1:0] res,
                                input logic [1:0] alu, input logic ill, input int gap);
        exp_t e;
        e.pc = pc; e.base_imm = bi; e.imm_src = imm; e.rs1 = r1; e.rs2 = r2;
        e.rd = rdd; e.ctl = ctl; e.res = res; e.alu = alu; e.ill = ill; e.gap = gap;
        return e;
    endfunction

    // Monitor: every fire pops the oldest expectation
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_fire: pc %0h fired with empty scoreboard", out_pc);
            end else begin
                m_e = sb.pop_front();
                chk("out_pc", out_pc, m_e.pc);
                chk("base_imm", 32'(base_imm), 32'(m_e.base_imm));
                chk("imm_src", 32'(imm_src), 32'(m_e.imm_src));
                chk("rs1", 32'(rs1), 32'(m_e.rs1));
                chk("rs2", 32'(rs2), 32'(m_e.rs2));
                chk("rd", 32'(rd), 32'(m_e.rd));
                chk("ctl_bits", 32'({reg_write, mem_write, alu_src, branch, jump}), 32'(m_e.ctl));
                chk("result_src", 32'(result_src), 32'(m_e.res));
                chk("alu_op", 32'(alu_op), 32'(m_e.alu));
                chk("illegal", 32'(illegal), 32'(m_e.ill));
                if (m_e.gap > 0) chk("fire_gap", 32'(cyc - last_fire), 32'(m_e.gap));
            end
            last_fire = cyc;
        end
    end

    task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                        input bit push, input exp_t e);
        int waited;
        waited = 0;
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        @(negedge clock);
        while (!in_ready && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: pc %0h in_ready stayed 0 expected 1", pc);
        end else if (push) begin
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t none;
        int   drain;
        none = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0;
        flush = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Reset / idle state
        @(negedge clock);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_imm_src", 32'(imm_src), 0);
        chk("rst_ctl_bits", 32'({reg_write, mem_write, alu_src, branch, jump}), 0);
        chk("rst_result_alu", 32'({result_src, alu_op}), 0);
        chk("rst_base_imm", 32'(base_imm), 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_illegal", 32'(illegal), 0);
        @(posedge clock); #1;

        // Back-to-back stream, then load-use pairs
        send(32'h00500093, 32'h100, 1, mk(32'h100, 25'h0A001, 2'b00, 0, 5, 1, 5'b10100, 2'b00, 2'b10, 0, 0));
        send(32'h00112223, 32'h104, 1, mk(32'h104, 25'h02244, 2'b01, 2, 1, 4, 5'b01100, 2'b00, 2'b00, 0, 1));
        send(32'h00208463, 32'h108, 1, mk(32'h108, 25'h04108, 2'b10, 1, 2, 8, 5'b00010, 2'b00, 2'b01, 0, 1));
        send(32'h008000EF, 32'h10C, 1, mk(32'h10C, 25'h10001, 2'b11, 0, 0, 1, 5'b10001, 2'b10, 2'b00, 0, 1));
        send(32'h0000A283, 32'h200, 1, mk(32'h200, 25'h00145, 2'b00, 1, 0, 5, 5'b10100, 2'b01, 2'b00, 0, 1));
        send(32'h00728333, 32'h204, 1, mk(32'h204, 25'h0E506, 2'b00, 5, 7, 6, 5'b10000, 2'b00, 2'b10, 0, 2));
        send(32'h0000A003, 32'h208, 1, mk(32'h208, 25'h00140, 2'b00, 1, 0, 0, 5'b10100, 2'b01, 2'b00, 0, 1));
        send(32'h00700333, 32'h20C, 1, mk(32'h20C, 25'h0E006, 2'b00, 0, 7, 6, 5'b10000, 2'b00, 2'b10, 0, 1));
        in_valid = 1'b0;
        repeat (2) @(posedge clock); #1;

        // Back-pressure: held bundle stable, next accepted on release
        out_ready = 1'b0;
        send(32'h00112223, 32'h300, 1, mk(32'h300, 25'h02244, 2'b01, 2, 1, 4, 5'b01100, 2'b00, 2'b00, 0, 0));
        in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h304;
        repeat (3) begin
            @(negedge clock);
            chk("stall_out_valid", 32'(out_valid), 1);
            chk("stall_in_ready", 32'(in_ready), 0);
            chk("stall_out_pc", out_pc, 32'h300);
            chk("stall_base_imm", 32'(base_imm), 32'h02244);
            chk("stall_mem_write", 32'(mem_write), 1);
            @(posedge clock); #1;
        end
        out_ready = 1'b1;
        @(negedge clock);
        chk("release_in_ready", 32'(in_ready), 1);
        if (in_ready) sb.push_back(mk(32'h304, 25'h0A001, 2'b00, 0, 5, 1, 5'b10100, 2'b00, 2'b10, 0, 1));
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clock); #1;

        // Flush drops held and incoming, and cancels the pending load hazard
        send(32'h0000A283, 32'h400, 1, mk(32'h400, 25'h00145, 2'b00, 1, 0, 5, 5'b10100, 2'b01, 2'b00, 0, 0));
        in_valid = 1'b0;
        @(posedge clock); #1;
        out_ready = 1'b0;
        send(32'h00208463, 32'h404, 0, none);
        in_valid = 1'b1; in_instr = 32'h00728333; in_pc = 32'h408; flush = 1'b1;
        @(negedge clock);
        chk("flush_out_valid", 32'(out_valid), 0);
        chk("flush_in_ready", 32'(in_ready), 0);
        @(posedge clock); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clock);
        chk("post_flush_out_valid", 32'(out_valid), 0);
        @(posedge clock); #1;
        send(32'h00728333, 32'h40C, 1, mk(32'h40C, 25'h0E506, 2'b00, 5, 7, 6, 5'b10000, 2'b00, 2'b10, 0, 0));
        in_valid = 1'b0;
        @(negedge clock);
        chk("no_bubble_after_flush", 32'(out_valid), 1);
        @(posedge clock); #1;

        // Unsupported opcode
        send(32'h0000007F, 32'h500, 1, mk(32'h500, 25'h0, 2'b00, 0, 0, 0, 5'b00000, 2'b00, 2'b00, c_ILL_EN, 0));
        in_valid = 1'b0;
        @(negedge clock);
        chk("illegal_flag", 32'(illegal), 32'(c_ILL_EN));
        chk("illegal_reg_write", 32'(reg_write), 0);
        @(posedge clock); #1;

        // Asynchronous reset while a bundle is held
        out_ready = 1'b0;
        send(32'h00500093, 32'h600, 0, none);
        in_valid = 1'b0;
        @(negedge clock);
        chk("held_before_reset", 32'(out_valid), 1);
        reset = 1'b1;
        #1;
        chk("async_reset_out_valid", 32'(out_valid), 0);
        chk("async_reset_out_pc", out_pc, 0);
        chk("async_reset_reg_write", 32'(reg_write), 0);
        @(posedge clock); #1;
        reset = 1'b0; out_ready = 1'b1;

        drain = 0;
        while (sb.size() != 0 && drain < 20) begin
            @(negedge clock);
            drain++;
        end
        chk("scoreboard_drain", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
